sub_bytes_shift_rows: RTL
=========================

Name: sub_bytes_shift_rows

Overview:
- AES round stage directly upstream of the MixColumns stage. It applies SubBytes (S-box) to all 16 state bytes, then ShiftRows, and produces the 128-bit state that MixColumns consumes.
- The S-box is time-multiplexed over a configurable number of lanes, so the designer trades area against latency.
- Uses a start/done handshake that matches the neighbouring round stages.

Parameters:
- LANES, 4, number of S-box instances (bytes substituted per cycle). Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NCYC, 16/LANES, derived localparam (not overridable): the number of substitution cycles.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enableSubShift  input  1  start request, sampled on rising edge.
- state  input  128  [0:127]; byte i = state[8i +: 8]; byte index = 4*col + row (column-major).
- stateOut  output  128  [0:127] result, same byte ordering.
- subShiftBusy  output  1  high while an operation is in progress.
- subShiftDone  output  1  one-cycle pulse when stateOut is valid.

Behaviour:
- Reset (rst high at an edge): FSM goes to IDLE, lane counter = 0, stateOut = 128'd0, subShiftBusy = 0, subShiftDone = 0. Reset overrides everything, including an operation in progress; a partial result is discarded and subShiftDone does not pulse.
- FSM states and transitions:
  - IDLE: on enableSubShift = 1, capture state into an internal 128-bit register, clear counter, set busy, go to SUB.
  - SUB: each cycle, substitute bytes [cnt*LANES, cnt*LANES+LANES-1] of the captured register in place; cnt increments. After cnt = NCYC-1 is processed, go to SHIFT.
  - SHIFT: one cycle. stateOut[4c+r] = sub[4*((c+r) mod 4) + r] for r, c in 0..3. Pulse subShiftDone, clear busy, go to IDLE.
- Latency: start sampled at edge k; stateOut updated and subShiftDone = 1 after edge k+NCYC+1. Examples: 5 cycles at LANES=4, 17 at LANES=1, 2 at LANES=16.
- stateOut holds its value until the next completion or reset. It never shows partial results.
- enableSubShift while busy: ignored, with no queuing. Level-held enable: a new operation starts on the first edge in IDLE where it is high. Back-to-back operation therefore needs one IDLE cycle between operations.
- subShiftDone is high for exactly one cycle per accepted start.
- The input state is only sampled at the start edge; later changes to state have no effect.
- S-box is the FIPS-197 forward table (256 x 8, combinational).

Optional Feature:
- Macro: SUB_SHIFT_INV_CIPHER_EN.
- When defined, the block adds input port invCipher (1 bit), sampled with the start request and held for the whole operation.
  - invCipher = 1: lanes use the inverse S-box, and the SHIFT state applies InvShiftRows: stateOut[4c+r] = sub[4*((c-r) mod 4) + r].
  - invCipher = 0: forward behaviour, identical to the macro-off build.
- When undefined: no port and no inverse table, so the block is forward-cipher only.

Decomposition:
- Shared package aes_pkg holds:
  - typedef for the 128-bit state;
  - typedef for a byte;
  - localparams for the FSM state encoding (IDLE, SUB, SHIFT);
  - function shift_rows_idx(row, col, inv), used here and by the decrypt path.
- Sub-module aes_sbox (input byte, optional inv select, output byte): purely combinational, instantiated LANES times via generate.

Test Plan:
- All-zero vector: rst, then state = 128'h0 with one-cycle enable. Required: after NCYC+1 cycles, stateOut = all bytes 8'h63, subShiftDone pulses exactly once, busy was high for NCYC+1 cycles.
- FIPS-197 App. B round 1: state = 193de3bea0f4e22b9ac68d2ae9f84808. Required: stateOut = d4bf5d30e0b452aeb84111f11e2798e5. Run at LANES = 1, 4 and 16; latency must be 17, 5 and 2 cycles respectively.
- Busy-ignore: start with the FIPS vector, and hold enable with a new state = 128'h5353...53 through the operation. Required: the first result equals the FIPS output. The second operation starts on the first IDLE edge, giving stateOut = all 8'hed.
- Mid-operation reset: start the FIPS vector, assert rst for one cycle at cycle 2. Required: stateOut = 0, busy = 0, no done pulse. A subsequent all-zero run produces the all-63 result.
- Hold check: after completion, toggle the state input for 20 cycles with enable low. Required: stateOut and done stay unchanged.
- With SUB_SHIFT_INV_CIPHER_EN, invCipher = 1, state = d4bf5d30e0b452aeb84111f11e2798e5 taken as ShiftRows output and applied as inverse input. Required: stateOut = 193de3bea0f4e22b9ac68d2ae9f84808.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM encoding and ShiftRows index helper
package aes_pkg;

  typedef logic [0:127] state_t;
  typedef logic [7:0]   byte_t;

  // Round-stage FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SUB   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Source byte index for output byte (row, col) of ShiftRows / InvShiftRows.
  // Bytes are column-major, so index = 4*col + row = {col, row}.
  function automatic logic [3:0] shift_rows_idx(input logic [1:0] row,
                                                input logic [1:0] col,
                                                input logic       inv);
    logic [1:0] src_col;
    src_col = inv ? (col - row) : (col + row);
    return {src_col, row};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box; inverse table only with SUB_SHIFT_INV_CIPHER_EN
module aes_sbox
  import aes_pkg::*;
(
`ifdef SUB_SHIFT_INV_CIPHER_EN
  input  logic  inv,
`endif
  input  byte_t din,
  output byte_t dout
);

  localparam logic [0:2047] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_SHIFT_INV_CIPHER_EN
  localparam logic [0:2047] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign dout = inv ? INV_TABLE[8*din +: 8] : FWD_TABLE[8*din +: 8];
`else
  assign dout = FWD_TABLE[8*din +: 8];
`endif

endmodule

// File: rtl/sub_bytes_shift_rows.sv
// rtl/sub_bytes_shift_rows.sv - lane-multiplexed SubBytes + ShiftRows stage; optional SUB_SHIFT_INV_CIPHER_EN
module sub_bytes_shift_rows
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enableSubShift,
`ifdef SUB_SHIFT_INV_CIPHER_EN
  input  logic         invCipher,
`endif
  input  logic [0:127] state,
  output logic [0:127] stateOut,
  output logic         subShiftBusy,
  output logic         subShiftDone
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_shift_rows: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    fsm;
  logic [CW-1:0] cnt;
  state_t        work;
  state_t        shifted;
  logic          inv_sel;
  logic [3:0]    lane_idx [LANES];
  byte_t         lane_out [LANES];

`ifdef SUB_SHIFT_INV_CIPHER_EN
  logic inv_q;

  // Direction is latched with the start request and held for the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (fsm == ST_IDLE && enableSubShift) begin
      inv_q <= invCipher;
    end
  end

  assign inv_sel = inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  // Each lane substitutes one byte of the current chunk of LANES bytes.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(int'(cnt) * LANES + l);
    aes_sbox u_sbox (
`ifdef SUB_SHIFT_INV_CIPHER_EN
      .inv  (inv_sel),
`endif
      .din  (work[8*lane_idx[l] +: 8]),
      .dout (lane_out[l])
    );
  end

  // Row rotation of the fully substituted state, forward or inverse.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(4*c + r) +: 8] = work[8*shift_rows_idx(2'(r), 2'(c), inv_sel) +: 8];
      end
    end
  end

  // Control FSM: capture, substitute in place chunk by chunk, then publish shifted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= ST_IDLE;
      cnt          <= '0;
      work         <= '0;
      stateOut     <= '0;
      subShiftBusy <= 1'b0;
      subShiftDone <= 1'b0;
    end else begin
      subShiftDone <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (enableSubShift) begin
            work         <= state;
            cnt          <= '0;
            subShiftBusy <= 1'b1;
            fsm          <= ST_SUB;
          end
        end
        ST_SUB: begin
          for (int l = 0; l < LANES; l++) begin
            work[8*lane_idx[l] +: 8] <= lane_out[l];
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            fsm <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          stateOut     <= shifted;
          subShiftDone <= 1'b1;
          subShiftBusy <= 1'b0;
          fsm          <= ST_IDLE;
        end
        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
